// File: rtl/ks_pg_stage.sv
// Generate/propagate pre-stage feeding the Kogge-Stone prefix tree.
// Two-entry output buffer (OR + skid) gives full rate with registered in_ready.
module ks_pg_stage #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_g,
    output logic [WIDTH-1:0] out_p,
    output logic             out_cin
);

    typedef struct packed {
        logic [WIDTH-1:0] g;
        logic [WIDTH-1:0] p;
        logic             c;
    } beat_t;

    beat_t            beat;
    logic [WIDTH-1:0] b_eff;
    logic             c_eff;

    beat_t or_q, or_d;
    beat_t sk_q, sk_d;
    logic  ov_q, ov_d;
    logic  skv_q, skv_d;
    logic  rdy_q, rdy_d;

    logic  accept;
    logic  pop;

    // Carry-in is folded into g[0] so the tree's first row needs no extra input.
    always_comb begin
        b_eff  = sub ? ~b : b;
        c_eff  = sub | cin;
        beat.p = a ^ b_eff;
        beat.g = a & b_eff;
        beat.g[0] = (a[0] & b_eff[0]) | (beat.p[0] & c_eff);
        beat.c = c_eff;
    end

    assign accept = in_valid & rdy_q;
    assign pop    = ov_q & out_ready;

    always_comb begin
        or_d  = or_q;
        sk_d  = sk_q;
        ov_d  = ov_q;
        skv_d = skv_q;
        if (pop && skv_q) begin
            or_d  = sk_q;
            skv_d = 1'b0;
        end else if (pop) begin
            if (accept) begin
                or_d = beat;
            end else begin
                ov_d = 1'b0;
            end
        end else if (!ov_q) begin
            if (accept) begin
                or_d = beat;
                ov_d = 1'b1;
            end
        end else if (accept) begin
            sk_d  = beat;
            skv_d = 1'b1;
        end
        rdy_d = ~skv_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            or_q  <= '0;
            sk_q  <= '0;
            ov_q  <= 1'b0;
            skv_q <= 1'b0;
            rdy_q <= 1'b0;
        end else begin
            or_q  <= or_d;
            sk_q  <= sk_d;
            ov_q  <= ov_d;
            skv_q <= skv_d;
            rdy_q <= rdy_d;
        end
    end

    assign in_ready  = rdy_q;
    assign out_valid = ov_q;
    assign out_g     = or_q.g;
    assign out_p     = or_q.p;
    assign out_cin   = or_q.c;

endmodule
